control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have these ports. Signals are listed as name, direction, width, meaning; clock and reset are listed first.
- clk, in, 1: single clock; all state changes occur on the rising edge.
- clr, in, 1: reset, asynchronous and active-low.
- IR, in, 32: instruction register contents.
- CON_FF_result, in, 1: branch condition flip-flop output.
- stop, in, 1: halt request, sampled in T0.
- run, out, 1: 1 while executing, 0 in RESET or HALT.
- alu_control, out, 5: ALU operation code.
- Datapath strobes, out, 1 each:
  - Gra, Grb, Grc, Rin, Rout, BAout
  - PCout, PCin, pc_increment
  - IRin, MARin, MDRin, MDRout, read, memoryRead, memoryWrite
  - RYin, Zhighin, Zlowin, Zhighout, Zlowout
  - HIin, LOin, HIout, LOout
  - Cout, CON_FF_in, InPort_read, OutPort_write
REQ-002 The opcode SHALL be IR[31:27], decoded as follows (binary):
- ld 00000, ldi 00001, st 00010
- add 00011, sub 00100, and 00101, or 00110
- addi 01000, andi 01001, ori 01010
- mul 01111, br 10010, jr 10011
- in 10110, out 10111, mflo 11000, mfhi 11001
- nop 11010, halt 11011
- Any other opcode SHALL be executed as nop.
REQ-003 ALU codes SHALL be ADD 00011, SUB 00100, AND 00101, OR 00110, MUL 01111.
- addi, andi and ori SHALL map to ADD, AND and OR respectively.
- ld, ldi, st and br SHALL use ADD.
- alu_control SHALL be 00000 in every state that does not list an operation.

Function
REQ-004 The controller SHALL be a Moore FSM: every output is decoded only from the registered state, one step per clk.
- Any strobe not listed for a step SHALL be 0.
- Execution steps are T3..T7, as the sequences below require.
REQ-005 Fetch SHALL take three steps:
- T0: PCout, MARin, pc_increment.
- T1: memoryRead, read, MDRin.
- T2: MDRout, IRin.
- IR SHALL be sampled for decode only when leaving T2.
REQ-006 R-type (add/sub/and/or):
- T3: Grb, Rout, RYin.
- T4: Grc, Rout, alu_control = op, Zlowin.
- T5: Zlowout, Gra, Rin.
- Then T0.
REQ-007 Immediate (addi/andi/ori):
- T3: Grb, Rout, RYin.
- T4: Cout, alu_control = op, Zlowin.
- T5: Zlowout, Gra, Rin.
- Then T0.
REQ-008 ldi:
- T3: Grb, BAout, Rout, RYin.
- T4: Cout, ADD, Zlowin.
- T5: Zlowout, Gra, Rin.
- Then T0.
REQ-009 ld:
- T3–T4 as ldi.
- T5: Zlowout, MARin.
- T6: memoryRead, read, MDRin.
- T7: MDRout, Gra, Rin.
- Then T0.
REQ-010 st:
- T3–T5 as ld.
- T6: Gra, Rout, MDRin, with read = 0.
- T7: memoryWrite.
- Then T0.
REQ-011 mul:
- T3: Gra, Rout, RYin.
- T4: Grb, Rout, MUL, Zhighin, Zlowin.
- T5: Zlowout, LOin.
- T6: Zhighout, HIin.
- Then T0.
REQ-012 br:
- T3: Gra, Rout, CON_FF_in.
- T4: PCout, RYin.
- T5: Cout, ADD, Zlowin.
- T6: Zlowout, and PCin only if CON_FF_result = 1 during T6.
- Then T0.
REQ-013 Single-step instructions SHALL execute in T3, then return to T0:
- jr: Gra, Rout, PCin.
- mfhi: HIout, Gra, Rin.
- mflo: LOout, Gra, Rin.
- in: InPort_read, Gra, Rin.
- out: Gra, Rout, OutPort_write.
- nop: T2 SHALL go directly to T0 with no T3.
REQ-014 halt or stop:
- Decoding halt in T2 SHALL enter HALT.
- stop = 1 sampled in T0 SHALL complete the fetch, then enter HALT from T2 instead of decoding.
- HALT SHALL drive all strobes to 0 and run = 0, and SHALL stay in HALT until clr.
REQ-015 Control rules:
- Rin and Rout SHALL never be 1 in the same step.
- At most one bus-source strobe (Rout, PCout, MDRout, Zlowout, Zhighout, HIout, LOout, Cout, InPort_read) SHALL be 1 per step.
- memoryRead and memoryWrite SHALL never be 1 in the same step.
REQ-016 The number of cycles from T0 back to T0 SHALL be:
- nop: 3
- jr, mfhi, mflo, in, out: 4
- R-type, immediate, ldi: 6
- mul, br: 7
- ld, st: 8

Reset
REQ-017 clr = 0 SHALL force state RESET immediately (asynchronously), with all outputs 0 and run = 0.
- This SHALL apply from any state, including mid-instruction.
- No partial strobe SHALL persist after clr falls.
REQ-018 On the first rising clk after clr returns to 1, the FSM SHALL move from RESET to T0.
- run SHALL be 1 from T0 onward.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- add R1,R2,R3 (IR = 0x18918000) -> T3 RYin + Grb; T4 alu_control = 00011, Grc, Zlowin; T5 Gra + Rin; back at T0 after 6 cycles.
- ld R2,0x55(R0) (IR = 0x01000055) -> T3 BAout; T5 MARin; T6 memoryRead + read; T7 Rin + Gra; 8 cycles total.
- br taken (IR = 0x93180014, CON_FF_result = 1) -> PCin = 1 in T6 only. Same IR with CON_FF_result = 0 -> PCin stays 0 for the whole instruction.
- halt (IR = 0xD8000000) -> HALT after T2, run = 0, outputs frozen at 0 for 20 cycles.
- clr pulsed low during T4 of mul -> all outputs 0 within the same cycle; T0 on the first edge after release.
- Every cycle of every test: check the REQ-015 exclusivity rules and that unused opcode 11111 executes as nop (3 cycles).

Source files
------------

// File: rtl/control_unit.sv
// Hardwired Moore controller: three-step fetch (T0-T2), up to five execute steps (T3-T7).
// The opcode is captured on the T2->T3 edge; every strobe is decoded from the registered state.
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON_FF_result,
    input  logic        stop,
    output logic        run,
    output logic [4:0]  alu_control,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCout,
    output logic        PCin,
    output logic        pc_increment,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        read,
    output logic        memoryRead,
    output logic        memoryWrite,
    output logic        RYin,
    output logic        Zhighin,
    output logic        Zlowin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        LOin,
    output logic        HIout,
    output logic        LOout,
    output logic        Cout,
    output logic        CON_FF_in,
    output logic        InPort_read,
    output logic        OutPort_write
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_e;

    typedef enum logic [4:0] {
        OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
        OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
        OP_OR   = 5'b00110, OP_ADDI = 5'b01000, OP_ANDI = 5'b01001,
        OP_ORI  = 5'b01010, OP_MUL  = 5'b01111, OP_BR   = 5'b10010,
        OP_JR   = 5'b10011, OP_IN   = 5'b10110, OP_OUT  = 5'b10111,
        OP_MFLO = 5'b11000, OP_MFHI = 5'b11001, OP_NOP  = 5'b11010,
        OP_HALT = 5'b11011
    } opcode_e;

    typedef enum logic [4:0] {
        ALU_NONE = 5'b00000, ALU_ADD = 5'b00011, ALU_SUB = 5'b00100,
        ALU_AND  = 5'b00101, ALU_OR  = 5'b00110, ALU_MUL = 5'b01111
    } alu_e;

    state_e     state_q, state_d;
    logic [4:0] op_q, op_d;
    logic       stop_q, stop_d;

    logic unused_ir_bits;
    assign unused_ir_bits = ^IR[26:0];

    // Final execute step per opcode; 0 means the instruction ends after fetch (nop / unknown).
    function automatic logic [2:0] last_step(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:       last_step = 3'd5;
            OP_LD, OP_ST:                           last_step = 3'd7;
            OP_MUL, OP_BR:                          last_step = 3'd6;
            OP_JR, OP_MFHI, OP_MFLO, OP_IN, OP_OUT: last_step = 3'd3;
            default:                                last_step = 3'd0;
        endcase
    endfunction

    function automatic logic [4:0] alu_of(input logic [4:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_LD, OP_LDI, OP_ST, OP_BR: alu_of = ALU_ADD;
            OP_SUB:                                       alu_of = ALU_SUB;
            OP_AND, OP_ANDI:                              alu_of = ALU_AND;
            OP_OR, OP_ORI:                                alu_of = ALU_OR;
            OP_MUL:                                       alu_of = ALU_MUL;
            default:                                      alu_of = ALU_NONE;
        endcase
    endfunction

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_RESET;
            op_q    <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            stop_q  <= stop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        stop_d  = stop_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0: begin
                stop_d  = stop;
                state_d = S_T1;
            end
            S_T1: state_d = S_T2;
            S_T2: begin
                op_d = IR[31:27];
                if (stop_q || IR[31:27] == OP_HALT)
                    state_d = S_HALT;
                else if (last_step(IR[31:27]) == 3'd0)
                    state_d = S_T0;
                else
                    state_d = S_T3;
            end
            S_T3:    state_d = (last_step(op_q) == 3'd3) ? S_T0 : S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = (last_step(op_q) == 3'd5) ? S_T0 : S_T6;
            S_T6:    state_d = (last_step(op_q) == 3'd6) ? S_T0 : S_T7;
            S_T7:    state_d = S_T0;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    assign run = (state_q != S_RESET) && (state_q != S_HALT);

    always_comb begin
        alu_control   = ALU_NONE;
        Gra           = 1'b0;
        Grb           = 1'b0;
        Grc           = 1'b0;
        Rin           = 1'b0;
        Rout          = 1'b0;
        BAout         = 1'b0;
        PCout         = 1'b0;
        PCin          = 1'b0;
        pc_increment  = 1'b0;
        IRin          = 1'b0;
        MARin         = 1'b0;
        MDRin         = 1'b0;
        MDRout        = 1'b0;
        read          = 1'b0;
        memoryRead    = 1'b0;
        memoryWrite   = 1'b0;
        RYin          = 1'b0;
        Zhighin       = 1'b0;
        Zlowin        = 1'b0;
        Zhighout      = 1'b0;
        Zlowout       = 1'b0;
        HIin          = 1'b0;
        LOin          = 1'b0;
        HIout         = 1'b0;
        LOout         = 1'b0;
        Cout          = 1'b0;
        CON_FF_in     = 1'b0;
        InPort_read   = 1'b0;
        OutPort_write = 1'b0;
        case (state_q)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; pc_increment = 1'b1;
            end
            S_T1: begin
                memoryRead = 1'b1; read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                case (op_q)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
                        Grb = 1'b1; Rout = 1'b1; RYin = 1'b1;
                    end
                    OP_LD, OP_LDI, OP_ST: begin
                        Grb = 1'b1; BAout = 1'b1; Rout = 1'b1; RYin = 1'b1;
                    end
                    OP_MUL: begin
                        Gra = 1'b1; Rout = 1'b1; RYin = 1'b1;
                    end
                    OP_BR: begin
                        Gra = 1'b1; Rout = 1'b1; CON_FF_in = 1'b1;
                    end
                    OP_JR: begin
                        Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                    end
                    OP_MFHI: begin
                        HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    OP_MFLO: begin
                        LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    OP_IN: begin
                        InPort_read = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    OP_OUT: begin
                        Gra = 1'b1; Rout = 1'b1; OutPort_write = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (op_q)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        Grc = 1'b1; Rout = 1'b1; alu_control = alu_of(op_q); Zlowin = 1'b1;
                    end
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LD, OP_LDI, OP_ST: begin
                        Cout = 1'b1; alu_control = alu_of(op_q); Zlowin = 1'b1;
                    end
                    OP_MUL: begin
                        Grb = 1'b1; Rout = 1'b1; alu_control = alu_of(op_q);
                        Zhighin = 1'b1; Zlowin = 1'b1;
                    end
                    OP_BR: begin
                        PCout = 1'b1; RYin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (op_q)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        Zlowout = 1'b1; MARin = 1'b1;
                    end
                    OP_MUL: begin
                        Zlowout = 1'b1; LOin = 1'b1;
                    end
                    OP_BR: begin
                        Cout = 1'b1; alu_control = alu_of(op_q); Zlowin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (op_q)
                    OP_LD: begin
                        memoryRead = 1'b1; read = 1'b1; MDRin = 1'b1;
                    end
                    OP_ST: begin
                        Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                    end
                    OP_MUL: begin
                        Zhighout = 1'b1; HIin = 1'b1;
                    end
                    OP_BR: begin
                        // Branch target load is gated by the live condition flag.
                        Zlowout = 1'b1; PCin = CON_FF_result;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (op_q)
                    OP_LD: begin
                        MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    OP_ST: memoryWrite = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomized instruction stream checked step-by-step against a table-driven model of the
// controller's per-instruction strobe sequences, plus directed reset/halt/branch scenarios.
module tb_control_unit;

    typedef logic [34:0] vec_t;

    localparam vec_t M_OUTW  = vec_t'(1) << 0;
    localparam vec_t M_INPR  = vec_t'(1) << 1;
    localparam vec_t M_CONIN = vec_t'(1) << 2;
    localparam vec_t M_COUT  = vec_t'(1) << 3;
    localparam vec_t M_LOOUT = vec_t'(1) << 4;
    localparam vec_t M_HIOUT = vec_t'(1) << 5;
    localparam vec_t M_LOIN  = vec_t'(1) << 6;
    localparam vec_t M_HIIN  = vec_t'(1) << 7;
    localparam vec_t M_ZLOUT = vec_t'(1) << 8;
    localparam vec_t M_ZHOUT = vec_t'(1) << 9;
    localparam vec_t M_ZLIN  = vec_t'(1) << 10;
    localparam vec_t M_ZHIN  = vec_t'(1) << 11;
    localparam vec_t M_RYIN  = vec_t'(1) << 12;
    localparam vec_t M_MEMW  = vec_t'(1) << 13;
    localparam vec_t M_MEMR  = vec_t'(1) << 14;
    localparam vec_t M_READ  = vec_t'(1) << 15;
    localparam vec_t M_MDROUT= vec_t'(1) << 16;
    localparam vec_t M_MDRIN = vec_t'(1) << 17;
    localparam vec_t M_MARIN = vec_t'(1) << 18;
    localparam vec_t M_IRIN  = vec_t'(1) << 19;
    localparam vec_t M_PCINC = vec_t'(1) << 20;
    localparam vec_t M_PCIN  = vec_t'(1) << 21;
    localparam vec_t M_PCOUT = vec_t'(1) << 22;
    localparam vec_t M_BAOUT = vec_t'(1) << 23;
    localparam vec_t M_ROUT  = vec_t'(1) << 24;
    localparam vec_t M_RIN   = vec_t'(1) << 25;
    localparam vec_t M_GRC   = vec_t'(1) << 26;
    localparam vec_t M_GRB   = vec_t'(1) << 27;
    localparam vec_t M_GRA   = vec_t'(1) << 28;
    localparam vec_t M_RUN   = vec_t'(1) << 34;
    localparam vec_t A_ADD   = vec_t'(5'b00011) << 29;
    localparam vec_t A_SUB   = vec_t'(5'b00100) << 29;
    localparam vec_t A_AND   = vec_t'(5'b00101) << 29;
    localparam vec_t A_OR    = vec_t'(5'b00110) << 29;
    localparam vec_t A_MUL   = vec_t'(5'b01111) << 29;
    localparam vec_t BUS_MASK = M_ROUT | M_PCOUT | M_MDROUT | M_ZLOUT | M_ZHOUT |
                                M_HIOUT | M_LOOUT | M_COUT | M_INPR;
    localparam vec_t T0_VEC  = M_RUN | M_PCOUT | M_MARIN | M_PCINC;

    logic        clk, clr, CON_FF_result, stop;
    logic [31:0] IR;
    logic        run;
    logic [4:0]  alu_control;
    logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, pc_increment;
    logic IRin, MARin, MDRin, MDRout, read, memoryRead, memoryWrite;
    logic RYin, Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin, HIout, LOout;
    logic Cout, CON_FF_in, InPort_read, OutPort_write;

    control_unit dut (
        .clk(clk), .clr(clr), .IR(IR), .CON_FF_result(CON_FF_result), .stop(stop),
        .run(run), .alu_control(alu_control),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .PCout(PCout), .PCin(PCin), .pc_increment(pc_increment),
        .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .read(read),
        .memoryRead(memoryRead), .memoryWrite(memoryWrite),
        .RYin(RYin), .Zhighin(Zhighin), .Zlowin(Zlowin), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
        .Cout(Cout), .CON_FF_in(CON_FF_in), .InPort_read(InPort_read), .OutPort_write(OutPort_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t exp_vec;
    logic exp_valid = 1'b0;
    int   cur_step  = 0;
    vec_t got_seq[0:7];
    vec_t exp_seq[0:7];
    int   exp_len;
    logic exp_halt;

    function automatic vec_t pack_dut();
        return {run, alu_control, Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, pc_increment,
                IRin, MARin, MDRin, MDRout, read, memoryRead, memoryWrite, RYin, Zhighin,
                Zlowin, Zhighout, Zlowout, HIin, LOin, HIout, LOout, Cout, CON_FF_in,
                InPort_read, OutPort_write};
    endfunction

    function automatic void check(input string name, input vec_t got, input vec_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    function automatic void add_step(input vec_t v);
        exp_seq[exp_len] = v | M_RUN;
        exp_len++;
    endfunction

    // Instruction-level model: the list of strobe sets each opcode walks through.
    function automatic void build_seq(input logic [4:0] op, input logic con, input logic stopv);
        vec_t alu;
        exp_len  = 0;
        exp_halt = 1'b0;
        add_step(M_PCOUT | M_MARIN | M_PCINC);
        add_step(M_MEMR | M_READ | M_MDRIN);
        add_step(M_MDROUT | M_IRIN);
        if (stopv || op == 5'b11011) begin
            exp_halt = 1'b1;
            return;
        end
        case (op)
            5'b00011, 5'b01000: alu = A_ADD;
            5'b00100:           alu = A_SUB;
            5'b00101, 5'b01001: alu = A_AND;
            5'b00110, 5'b01010: alu = A_OR;
            default:            alu = '0;
        endcase
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                add_step(M_GRB | M_ROUT | M_RYIN);
                add_step(M_GRC | M_ROUT | alu | M_ZLIN);
                add_step(M_ZLOUT | M_GRA | M_RIN);
            end
            5'b01000, 5'b01001, 5'b01010: begin
                add_step(M_GRB | M_ROUT | M_RYIN);
                add_step(M_COUT | alu | M_ZLIN);
                add_step(M_ZLOUT | M_GRA | M_RIN);
            end
            5'b00001, 5'b00000, 5'b00010: begin
                add_step(M_GRB | M_BAOUT | M_ROUT | M_RYIN);
                add_step(M_COUT | A_ADD | M_ZLIN);
                if (op == 5'b00001) add_step(M_ZLOUT | M_GRA | M_RIN);
                else                add_step(M_ZLOUT | M_MARIN);
                if (op == 5'b00000) begin
                    add_step(M_MEMR | M_READ | M_MDRIN);
                    add_step(M_MDROUT | M_GRA | M_RIN);
                end else if (op == 5'b00010) begin
                    add_step(M_GRA | M_ROUT | M_MDRIN);
                    add_step(M_MEMW);
                end
            end
            5'b01111: begin
                add_step(M_GRA | M_ROUT | M_RYIN);
                add_step(M_GRB | M_ROUT | A_MUL | M_ZHIN | M_ZLIN);
                add_step(M_ZLOUT | M_LOIN);
                add_step(M_ZHOUT | M_HIIN);
            end
            5'b10010: begin
                add_step(M_GRA | M_ROUT | M_CONIN);
                add_step(M_PCOUT | M_RYIN);
                add_step(M_COUT | A_ADD | M_ZLIN);
                add_step(M_ZLOUT | (con ? M_PCIN : '0));
            end
            5'b10011: add_step(M_GRA | M_ROUT | M_PCIN);
            5'b11001: add_step(M_HIOUT | M_GRA | M_RIN);
            5'b11000: add_step(M_LOOUT | M_GRA | M_RIN);
            5'b10110: add_step(M_INPR | M_GRA | M_RIN);
            5'b10111: add_step(M_GRA | M_ROUT | M_OUTW);
            default: ;
        endcase
    endfunction

    // Single compare process: model step vs DUT, plus bus/port exclusivity every cycle.
    always @(negedge clk) begin
        vec_t v;
        v = pack_dut();
        if (exp_valid) begin
            check("step", v, exp_vec);
            if (cur_step >= 0 && cur_step < 8) got_seq[cur_step] = v;
        end
        check("excl_rin_rout", vec_t'(v[25] & v[24]), '0);
        check("excl_bus", vec_t'($countones(v & BUS_MASK) > 1), '0);
        check("excl_mem", vec_t'(v[14] & v[13]), '0);
    end

    // Entered at posedge+1 in T0; IR only carries the real instruction during T2.
    task automatic run_instr(input logic [31:0] ir, input logic con, input logic stopv,
                             input int abort_at);
        build_seq(ir[31:27], con, stopv);
        for (int i = 0; i < exp_len; i++) begin
            cur_step  = i;
            exp_vec   = exp_seq[i];
            exp_valid = 1'b1;
            IR        = (i == 2) ? ir : $urandom;
            stop      = (i == 0) ? stopv : 1'($urandom);
            CON_FF_result = (ir[31:27] == 5'b10010 && i == 6) ? con : 1'($urandom);
            if (i == abort_at) begin
                #1 check("abort_step", pack_dut(), exp_seq[i]);
                #1 exp_vec = '0;
                clr = 1'b0;
                #1 check("clr_async_zero", pack_dut(), '0);
                return;
            end
            @(posedge clk); #1;
        end
        cur_step = 8;
        if (exp_halt) exp_vec = '0;
    endtask

    // Entered mid-cycle with clr already low; leaves at posedge+1 in T0.
    task automatic release_reset();
        exp_vec = '0;
        @(posedge clk); #1;
        check("held_reset_zero", pack_dut(), '0);
        #2 clr = 1'b1;
        @(posedge clk); #1;
        exp_vec = T0_VEC;
        check("t0_after_release", pack_dut(), T0_VEC);
    endtask

    task automatic do_reset();
        #2 exp_vec = '0;
        clr = 1'b0;
        #1 check("clr_async_zero", pack_dut(), '0);
        release_reset();
    endtask

    task automatic halt_hold(input int n);
        exp_vec = '0;
        repeat (n) begin
            IR = $urandom; stop = 1'($urandom); CON_FF_result = 1'($urandom);
            @(posedge clk); #1;
            check("halt_run_low", vec_t'(run), '0);
        end
    endtask

    // Counts DUT cycles from T0 back to T0, with the instruction held on IR throughout.
    task automatic measure(input string name, input logic [31:0] ir, input int exp_cycles);
        int cnt;
        exp_valid = 1'b0;
        IR = ir; stop = 1'b0; CON_FF_result = 1'b0;
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (pack_dut() !== T0_VEC && cnt < 20);
        check(name, vec_t'(cnt), vec_t'(exp_cycles));
    endtask

    initial begin
        clr = 1'b1; IR = '0; CON_FF_result = 1'b0; stop = 1'b0;
        #1 clr = 1'b0;
        #1 check("reset_async_zero", pack_dut(), '0);
        exp_vec = '0; exp_valid = 1'b1;
        repeat (2) @(posedge clk);
        #3 clr = 1'b1;
        @(posedge clk); #1;
        exp_vec = T0_VEC;
        check("first_t0", pack_dut(), T0_VEC);

        run_instr(32'h18918000, 1'b0, 1'b0, -1);
        check("add_t3", got_seq[3], M_RUN | M_GRB | M_ROUT | M_RYIN);
        check("add_t4", got_seq[4], M_RUN | A_ADD | M_GRC | M_ROUT | M_ZLIN);
        check("add_t5", got_seq[5], M_RUN | M_ZLOUT | M_GRA | M_RIN);
        measure("add_cycles", 32'h18918000, 6);

        run_instr(32'h01000055, 1'b0, 1'b0, -1);
        check("ld_t3", got_seq[3], M_RUN | M_GRB | M_BAOUT | M_ROUT | M_RYIN);
        check("ld_t5", got_seq[5], M_RUN | M_ZLOUT | M_MARIN);
        check("ld_t6", got_seq[6], M_RUN | M_MEMR | M_READ | M_MDRIN);
        check("ld_t7", got_seq[7], M_RUN | M_MDROUT | M_GRA | M_RIN);
        measure("ld_cycles", 32'h01000055, 8);

        run_instr(32'h93180014, 1'b1, 1'b0, -1);
        check("br_taken_t6", got_seq[6], M_RUN | M_ZLOUT | M_PCIN);
        for (int i = 0; i < 6; i++) check("br_taken_pcin_early", vec_t'(got_seq[i][21]), '0);
        run_instr(32'h93180014, 1'b0, 1'b0, -1);
        for (int i = 0; i < 7; i++) check("br_not_taken_pcin", vec_t'(got_seq[i][21]), '0);
        measure("br_cycles", 32'h93180014, 7);

        measure("mul_cycles", 32'h7A180000, 7);
        measure("jr_cycles", 32'h98800000, 4);
        measure("st_cycles", 32'h11000010, 8);
        measure("nop_cycles", 32'hD0000000, 3);
        measure("op11111_cycles", 32'hF8000000, 3);
        run_instr(32'hF8001234, 1'b0, 1'b0, -1);

        for (int n = 0; n < 400; n++) begin
            logic [4:0] op;
            op = 5'($urandom_range(0, 31));
            if (op == 5'b11011) op = 5'b11111;
            run_instr({op, 27'($urandom)}, 1'($urandom), 1'b0, -1);
        end

        run_instr(32'h7A180000, 1'b0, 1'b0, 4);
        release_reset();
        run_instr(32'h18918000, 1'b0, 1'b0, -1);

        run_instr(32'hD8000000, 1'b0, 1'b0, -1);
        halt_hold(20);
        do_reset();

        run_instr(32'h18918000, 1'b0, 1'b1, -1);
        halt_hold(5);
        do_reset();
        run_instr(32'h28800007, 1'b0, 1'b0, -1);

        exp_valid = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
